// File: rtl/pet_stats_engine.sv
// pet_stats_engine
//   NUM_STATS saturating pet stat counters (index 0 = energy) driven by a
//   built-in tick prescaler, random decay, a valid/ready boost/sleep/wake
//   command port and an AWAKE/SLEEP/DEAD lifecycle with a starvation timer.
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   ena                   prescaler advances only when high
//   rand_in[7:0]          random byte; bit i%8 gates decay of stat i (i>=1)
//   cmd_valid, cmd_id     command request; 0..N-1 boost, N sleep, N+1 wake
//   cmd_ready             high unless DEAD (combinational)
//   cmd_err               1-cycle pulse: invalid id, or boost while asleep
//   stats_flat            stat i at [i*STAT_W +: STAT_W]
//   tick                  1-cycle pulse at prescaler wrap
//   is_sleeping, is_dead  lifecycle state flags
//   alarm                 any stat == 0
module pet_stats_engine #(
  parameter int NUM_STATS  = 5,
  parameter int STAT_W     = 5,
  parameter int TICK_DIV   = 10_000_000,
  parameter int BOOST      = 8,
  parameter int SLEEP_TH   = 4,
  parameter int DEAD_TICKS = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  input  logic [7:0]                  rand_in,
  input  logic                        cmd_valid,
  input  logic [7:0]                  cmd_id,
  output logic                        cmd_ready,
  output logic                        cmd_err,
  output logic [NUM_STATS*STAT_W-1:0] stats_flat,
  output logic                        tick,
  output logic                        is_sleeping,
  output logic                        is_dead,
  output logic                        alarm
);

  localparam int MAX   = (1 << STAT_W) - 1;
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int STV_W = (DEAD_TICKS > 0) ? $clog2(DEAD_TICKS + 1) : 1;
  localparam int EXT_W = STAT_W + 2;

  localparam logic signed [EXT_W-1:0] MAX_X      = EXT_W'(MAX);
  localparam logic signed [EXT_W-1:0] BOOST_X    = EXT_W'(BOOST);
  localparam logic signed [EXT_W-1:0] ONE_X      = EXT_W'(1);
  localparam logic signed [EXT_W-1:0] TWO_X      = EXT_W'(2);
  localparam logic [CNT_W-1:0]        CNT_LAST   = CNT_W'(TICK_DIV - 1);
  localparam logic [STV_W-1:0]        STARVE_LIM = STV_W'(DEAD_TICKS);
  localparam logic [7:0]              ID_SLEEP   = 8'(NUM_STATS);
  localparam logic [7:0]              ID_WAKE    = 8'(NUM_STATS + 1);
  localparam logic [STAT_W-1:0]       SLEEP_LVL  = STAT_W'(SLEEP_TH);
  localparam logic [STAT_W-1:0]       STAT_MAX   = STAT_W'(MAX);

  typedef enum logic [1:0] {AWAKE = 2'd0, SLEEP = 2'd1, DEAD = 2'd2} state_t;

  // Clamp an extended signed intermediate back into 0..MAX.
  function automatic logic [STAT_W-1:0] sat_stat(input logic signed [EXT_W-1:0] v);
    logic [STAT_W-1:0] r;
    if (v[EXT_W-1])   r = '0;
    else if (v > MAX_X) r = STAT_MAX;
    else              r = v[STAT_W-1:0];
    return r;
  endfunction

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q;
  logic [STV_W-1:0]            starve_q, starve_d;
  logic [NUM_STATS*STAT_W-1:0] stats_q, stats_d;
  logic [NUM_STATS-1:0]        zero_vec;
  logic [STAT_W-1:0]           energy_d;
  logic                        accept, boost_cmd, sleep_cmd, wake_cmd, bad_cmd;
  logic                        live_tick, any_zero;

  assign cmd_ready  = (state_q != DEAD);
  assign stats_flat = stats_q;

  always_comb begin
    accept    = cmd_valid && cmd_ready;
    boost_cmd = accept && (cmd_id < ID_SLEEP);
    sleep_cmd = accept && (cmd_id == ID_SLEEP);
    wake_cmd  = accept && (cmd_id == ID_WAKE);
    bad_cmd   = accept && (cmd_id > ID_WAKE);
    live_tick = tick && (state_q != DEAD);
  end

  // Per-stat update: tick decay/recharge and boost fold into one clamped sum,
  // so a boost coinciding with a decaying tick is a single update.
  for (genvar g = 0; g < NUM_STATS; g++) begin : g_stat
    logic signed [EXT_W-1:0] sum;
    logic                    dec, inc2, add_boost;
    always_comb begin
      dec       = live_tick && (state_q == AWAKE) && ((g == 0) || rand_in[g % 8]);
      inc2      = live_tick && (state_q == SLEEP) && (g == 0);
      add_boost = boost_cmd && (state_q == AWAKE) && (cmd_id == 8'(g));
      sum       = $signed({2'b00, stats_q[g*STAT_W +: STAT_W]});
      if (dec)       sum = sum - ONE_X;
      if (inc2)      sum = sum + TWO_X;
      if (add_boost) sum = sum + BOOST_X;
    end
    assign stats_d[g*STAT_W +: STAT_W] = sat_stat(sum);
    assign zero_vec[g] = (stats_d[g*STAT_W +: STAT_W] == '0);
  end

  assign any_zero = |zero_vec;
  assign energy_d = stats_d[STAT_W-1:0];

  // Lifecycle: tick-driven transitions look at post-update values; an
  // accepted sleep/wake command has the final say on the next state.
  always_comb begin
    starve_d = starve_q;
    state_d  = state_q;
    if (live_tick) begin
      if (!any_zero)                  starve_d = '0;
      else if (starve_q != STARVE_LIM) starve_d = starve_q + 1'b1;
      if (state_q == AWAKE && energy_d <= SLEEP_LVL)     state_d = SLEEP;
      else if (state_q == SLEEP && energy_d == STAT_MAX) state_d = AWAKE;
      if (DEAD_TICKS != 0 && starve_d == STARVE_LIM)     state_d = DEAD;
    end
    if (sleep_cmd) state_d = SLEEP;
    if (wake_cmd)  state_d = AWAKE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      tick        <= 1'b0;
      stats_q     <= {NUM_STATS{STAT_MAX}};
      starve_q    <= '0;
      state_q     <= AWAKE;
      cmd_err     <= 1'b0;
      alarm       <= 1'b0;
      is_sleeping <= 1'b0;
      is_dead     <= 1'b0;
    end else begin
      if (ena) begin
        if (cnt_q == CNT_LAST) begin
          cnt_q <= '0;
          tick  <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
          tick  <= 1'b0;
        end
      end else begin
        tick <= 1'b0;
      end
      stats_q     <= stats_d;
      starve_q    <= starve_d;
      state_q     <= state_d;
      cmd_err     <= bad_cmd || (boost_cmd && state_q == SLEEP);
      alarm       <= any_zero;
      is_sleeping <= (state_d == SLEEP);
      is_dead     <= (state_d == DEAD);
    end
  end

endmodule
